// File: rtl/mov_dest_sequencer.sv
// mov_dest_sequencer: registered move-destination sequencer.
// Turns one accepted move command into one or more one-hot destination
// beats (single, burst with wrap-around, broadcast or explicit mask).
// Both the command and destination sides use valid/ready handshakes.
module mov_dest_sequencer #(
    parameter int DEST_W = 4,
    parameter int N_DEST = 2**DEST_W,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [DEST_W-1:0] cmd_dest,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic [N_DEST-1:0] cmd_mask,
    output logic [N_DEST-1:0] dest_onehot,
    output logic              dest_valid,
    input  logic              dest_ready,
    output logic              dest_last,
    output logic              busy
);

    localparam logic [1:0] MODE_SINGLE    = 2'b00;
    localparam logic [1:0] MODE_BURST     = 2'b01;
    localparam logic [1:0] MODE_BROADCAST = 2'b10;
    localparam logic [1:0] MODE_MASK      = 2'b11;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DEST_W-1:0]   idx;
    logic [DEST_W-1:0]   idx_nxt;
    logic [CNT_W-1:0]    remaining;
    logic [CNT_W-1:0]    remaining_nxt;
    logic [N_DEST-1:0]   onehot_nxt;
    logic                last_nxt;
    logic                accept;
    logic [DEST_W-1:0]   idx_inc;

    // Index to one-hot select; the index width always covers N_DEST.
    function automatic logic [N_DEST-1:0] decode(input logic [DEST_W-1:0] i);
        logic [N_DEST-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Handshake and status flags are decoded from registered state only.
    assign cmd_ready  = (state == IDLE);
    assign dest_valid = (state == ISSUE);
    assign busy       = (state == ISSUE);
    assign accept     = cmd_valid && (state == IDLE);
    assign idx_inc    = idx + DEST_W'(1);

    // State register; reset abandons any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Beat datapath registers: current index, remaining beats, outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            remaining   <= '0;
            dest_onehot <= '0;
            dest_last   <= 1'b0;
        end else begin
            idx         <= idx_nxt;
            remaining   <= remaining_nxt;
            dest_onehot <= onehot_nxt;
            dest_last   <= last_nxt;
        end
    end

    // Next-state and next-beat decode; holding by default gives stall stability.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        remaining_nxt = remaining;
        onehot_nxt    = dest_onehot;
        last_nxt      = dest_last;
        case (state)
            IDLE: begin
                if (accept && enable) begin
                    case (cmd_mode)
                        MODE_SINGLE: begin
                            onehot_nxt    = decode(cmd_dest);
                            last_nxt      = 1'b1;
                            idx_nxt       = cmd_dest;
                            remaining_nxt = '0;
                            state_nxt     = ISSUE;
                        end
                        MODE_BURST: begin
                            onehot_nxt    = decode(cmd_dest);
                            last_nxt      = (cmd_count == '0);
                            idx_nxt       = cmd_dest;
                            remaining_nxt = cmd_count;
                            state_nxt     = ISSUE;
                        end
                        MODE_BROADCAST: begin
                            onehot_nxt    = '1;
                            last_nxt      = 1'b1;
                            remaining_nxt = '0;
                            state_nxt     = ISSUE;
                        end
                        MODE_MASK: begin
                            if (cmd_mask != '0) begin
                                onehot_nxt    = cmd_mask;
                                last_nxt      = 1'b1;
                                remaining_nxt = '0;
                                state_nxt     = ISSUE;
                            end
                        end
                        default: begin
                            state_nxt = IDLE;
                        end
                    endcase
                end
            end
            ISSUE: begin
                if (dest_ready) begin
                    if (dest_last) begin
                        state_nxt     = IDLE;
                        onehot_nxt    = '0;
                        last_nxt      = 1'b0;
                        idx_nxt       = '0;
                        remaining_nxt = '0;
                    end else begin
                        idx_nxt       = idx_inc;
                        remaining_nxt = remaining - CNT_W'(1);
                        onehot_nxt    = decode(idx_inc);
                        last_nxt      = (remaining == CNT_W'(1));
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mov_dest_sequencer.sv
// tb_mov_dest_sequencer: directed bench with a beat scoreboard.
// Expected beats are queued when a command is driven and checked as the
// sequencer hands them off.
module tb_mov_dest_sequencer;

    localparam int DEST_W = 4;
    localparam int N_DEST = 16;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_mode;
    logic [DEST_W-1:0] cmd_dest;
    logic [CNT_W-1:0]  cmd_count;
    logic [N_DEST-1:0] cmd_mask;
    logic [N_DEST-1:0] dest_onehot;
    logic              dest_valid;
    logic              dest_ready;
    logic              dest_last;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    logic [N_DEST:0] sb[$];

    logic              prev_stall;
    logic [N_DEST-1:0] prev_onehot;
    logic              prev_last;

    mov_dest_sequencer #(
        .DEST_W(DEST_W),
        .N_DEST(N_DEST),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_dest   (cmd_dest),
        .cmd_count  (cmd_count),
        .cmd_mask   (cmd_mask),
        .dest_onehot(dest_onehot),
        .dest_valid (dest_valid),
        .dest_ready (dest_ready),
        .dest_last  (dest_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent model of the beats a command must produce.
    task automatic push_expected(input logic [1:0] mode, input int dest, input int count,
                                 input logic [N_DEST-1:0] mask, input logic en);
        logic [N_DEST-1:0] oh;
        if (!en) return;
        case (mode)
            2'b00: begin
                oh = '0; oh[dest] = 1'b1;
                sb.push_back({1'b1, oh});
            end
            2'b01: begin
                for (int i = 0; i <= count; i++) begin
                    oh = '0; oh[(dest + i) % N_DEST] = 1'b1;
                    sb.push_back({(i == count), oh});
                end
            end
            2'b10: sb.push_back({1'b1, {N_DEST{1'b1}}});
            default: if (mask != '0) sb.push_back({1'b1, mask});
        endcase
    endtask

    // Drive one command and release cmd_valid right after it is accepted.
    task automatic apply_stimulus(input logic [1:0] mode, input int dest, input int count,
                                  input logic [N_DEST-1:0] mask, input logic en);
        int n = 0;
        cmd_mode  = mode;
        cmd_dest  = DEST_W'(dest);
        cmd_count = CNT_W'(count);
        cmd_mask  = mask;
        enable    = en;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_output("accept_wait", (n < 50), 1);
        push_expected(mode, dest, count, mask, en);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || sb.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check_output("idle_wait", (n < budget), 1);
    endtask

    // Scoreboard and stall checker, sampling on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check_output("stall_valid", dest_valid, 1);
                check_output("stall_onehot", dest_onehot, prev_onehot);
                check_output("stall_last", dest_last, prev_last);
            end
            if (!dest_valid) begin
                check_output("idle_onehot", dest_onehot, 0);
            end
            if (dest_valid && dest_ready) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_beat", dest_onehot, 0);
                end else begin
                    logic [N_DEST:0] e;
                    e = sb.pop_front();
                    check_output("beat_onehot", dest_onehot, e[N_DEST-1:0]);
                    check_output("beat_last", dest_last, e[N_DEST]);
                end
            end
            prev_stall  <= dest_valid && !dest_ready;
            prev_onehot <= dest_onehot;
            prev_last   <= dest_last;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        rst_n      = 1'b0;
        enable     = 1'b0;
        cmd_valid  = 1'b0;
        cmd_mode   = 2'b00;
        cmd_dest   = '0;
        cmd_count  = '0;
        cmd_mask   = '0;
        dest_ready = 1'b1;

        // Reset values
        #3;
        check_output("rst_onehot", dest_onehot, 0);
        check_output("rst_valid", dest_valid, 0);
        check_output("rst_last", dest_last, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset while busy
        apply_stimulus(2'b01, 0, 5, '0, 1'b1);
        check_output("busy_before_rst", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("arst_onehot", dest_onehot, 0);
        check_output("arst_valid", dest_valid, 0);
        check_output("arst_busy", busy, 0);
        check_output("arst_cmd_ready", cmd_ready, 1);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single dest=5: one beat one cycle after accept
        apply_stimulus(2'b00, 5, 0, '0, 1'b1);
        check_output("single_valid", dest_valid, 1);
        check_output("single_onehot", dest_onehot, 32'h0020);
        check_output("single_last", dest_last, 1);
        check_output("single_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1;
        check_output("single_done_valid", dest_valid, 0);
        check_output("single_done_ready", cmd_ready, 1);
        wait_idle(20);

        // Burst wrap 14,15,0,1 on consecutive cycles
        apply_stimulus(2'b01, 14, 3, '0, 1'b1);
        n = 0;
        while (dest_valid && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        check_output("burst_wrap_cycles", n, 4);
        wait_idle(20);

        // Backpressure on beat 2 of burst 0..2
        apply_stimulus(2'b01, 0, 2, '0, 1'b1);
        @(posedge clk); #1;
        dest_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_output("bp_hold_onehot", dest_onehot, 32'h0002);
        end
        dest_ready = 1'b1;
        wait_idle(20);

        // Broadcast, mask, empty mask, disabled command
        apply_stimulus(2'b10, 0, 0, '0, 1'b1);
        check_output("bcast_onehot", dest_onehot, 32'hFFFF);
        wait_idle(20);
        apply_stimulus(2'b11, 0, 0, 16'h00A5, 1'b1);
        check_output("mask_onehot", dest_onehot, 32'h00A5);
        wait_idle(20);
        apply_stimulus(2'b11, 0, 0, 16'h0000, 1'b1);
        check_output("mask0_valid", dest_valid, 0);
        check_output("mask0_cmd_ready", cmd_ready, 1);
        apply_stimulus(2'b00, 3, 0, '0, 1'b0);
        check_output("dis_valid", dest_valid, 0);
        check_output("dis_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        check_output("dis_valid_later", dest_valid, 0);

        // Reset during beat 3 of a 10-beat burst
        apply_stimulus(2'b01, 0, 9, '0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_output("mid_beat3", dest_onehot, 32'h0004);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_onehot", dest_onehot, 0);
        check_output("mid_rst_last", dest_last, 0);
        check_output("mid_rst_valid", dest_valid, 0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        apply_stimulus(2'b00, 7, 0, '0, 1'b1);
        check_output("post_rst_onehot", dest_onehot, 32'h0080);
        wait_idle(20);

        // Back-to-back with cmd_valid held; inputs change after accept
        cmd_mode  = 2'b01;
        cmd_dest  = 4'd2;
        cmd_count = 4'd1;
        enable    = 1'b1;
        cmd_valid = 1'b1;
        push_expected(2'b01, 2, 1, '0, 1'b1);
        push_expected(2'b00, 9, 0, '0, 1'b1);
        @(posedge clk); #1;
        cmd_mode  = 2'b00;
        cmd_dest  = 4'd9;
        cmd_count = 4'd7;
        check_output("b2b_ready0_a", cmd_ready, 0);
        check_output("b2b_beat0", dest_onehot, 32'h0004);
        @(posedge clk); #1;
        check_output("b2b_ready0_b", cmd_ready, 0);
        check_output("b2b_beat1", dest_onehot, 32'h0008);
        check_output("b2b_beat1_last", dest_last, 1);
        @(posedge clk); #1;
        check_output("b2b_bubble_valid", dest_valid, 0);
        check_output("b2b_bubble_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check_output("b2b_second_valid", dest_valid, 1);
        check_output("b2b_second_onehot", dest_onehot, 32'h0200);
        wait_idle(20);

        check_output("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
